// File: rtl/servant_sim_uart.sv
// Bit-serial UART endpoint for the servant harness: RX decoder feeding a FWFT FIFO, plus a TX serialiser.
// Define SERVANT_UART_PARITY_EN to add an even-parity bit in both directions.
module servant_sim_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        wb_clk,
    input  logic                        wb_rst,
    input  logic                        i_rx,
    output logic                        o_tx,
    input  logic [DATA_BITS-1:0]        i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic [DATA_BITS-1:0]        o_rx_data,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_rx_count,
    output logic                        o_frame_err,
    output logic                        o_overflow,
    output logic                        o_parity_err
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- RX synchroniser ----------------
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= i_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // ---------------- RX FSM ----------------
    state_t                 rx_state_reg, rx_state_next;
    logic [CNT_W-1:0]       rx_cnt_reg, rx_cnt_next;
    logic [BIT_W-1:0]       rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0]   rx_shift_reg, rx_shift_next;
    logic                   rx_par_bad_reg, rx_par_bad_next;
    logic                   rx_tick, rx_push, frame_set, overflow_set, parity_set;
    logic                   fifo_full, fifo_pop;
    logic [AW:0]            wr_ptr_reg, rd_ptr_reg;

    assign rx_tick = (rx_cnt_reg == ((rx_state_reg == S_START) ? HALF_M1 : FULL_M1));

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rx_state_reg   <= S_IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_bad_reg <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            rx_cnt_reg     <= rx_cnt_next;
            rx_bit_reg     <= rx_bit_next;
            rx_shift_reg   <= rx_shift_next;
            rx_par_bad_reg <= rx_par_bad_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state_reg;
        rx_cnt_next     = rx_tick ? '0 : rx_cnt_reg + 1'b1;
        rx_bit_next     = rx_bit_reg;
        rx_shift_next   = rx_shift_reg;
        rx_par_bad_next = rx_par_bad_reg;
        rx_push         = 1'b0;
        frame_set       = 1'b0;
        overflow_set    = 1'b0;
        parity_set      = 1'b0;
        case (rx_state_reg)
            S_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) rx_state_next = S_START;
            end
            S_START: if (rx_tick) begin
                // A high mid-start sample is a glitch: drop silently.
                rx_state_next   = rx_sync_reg ? S_IDLE : S_DATA;
                rx_bit_next     = '0;
                rx_par_bad_next = 1'b0;
            end
            S_DATA: if (rx_tick) begin
                rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                rx_bit_next   = rx_bit_reg + 1'b1;
                if (rx_bit_reg == LAST_BIT) begin
`ifdef SERVANT_UART_PARITY_EN
                    rx_state_next = S_PARITY;
`else
                    rx_state_next = S_STOP;
`endif
                end
            end
            S_PARITY: if (rx_tick) begin
                rx_par_bad_next = rx_sync_reg ^ (^rx_shift_reg);
                rx_state_next   = S_STOP;
            end
            S_STOP: if (rx_tick) begin
                rx_state_next = S_IDLE;
                frame_set     = !rx_sync_reg;
                parity_set    = rx_par_bad_reg;
                if (rx_sync_reg && !rx_par_bad_reg) begin
                    if (fifo_full && !fifo_pop) overflow_set = 1'b1;
                    else                        rx_push      = 1'b1;
                end
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO (first-word fall-through) ----------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];

    assign o_rx_count = wr_ptr_reg - rd_ptr_reg;
    assign o_rx_valid = (o_rx_count != '0);
    assign fifo_full  = (o_rx_count == (AW+1)'(FIFO_DEPTH));
    assign fifo_pop   = o_rx_valid && i_rx_ready;
    assign o_rx_data  = fifo_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge wb_clk) begin
        if (rx_push) fifo_mem[wr_ptr_reg[AW-1:0]] <= rx_shift_reg;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (rx_push)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // ---------------- Sticky error flags ----------------
    logic frame_err_reg, overflow_reg;
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (frame_set)    frame_err_reg <= 1'b1;
            if (overflow_set) overflow_reg  <= 1'b1;
        end
    end
    assign o_frame_err = frame_err_reg;
    assign o_overflow  = overflow_reg;

`ifdef SERVANT_UART_PARITY_EN
    logic parity_err_reg;
    always_ff @(posedge wb_clk) begin
        if (wb_rst)          parity_err_reg <= 1'b0;
        else if (parity_set) parity_err_reg <= 1'b1;
    end
    assign o_parity_err = parity_err_reg;
`else
    assign o_parity_err = 1'b0;
`endif

    // ---------------- TX FSM ----------------
    state_t               tx_state_reg, tx_state_next;
    logic [CNT_W-1:0]     tx_cnt_reg, tx_cnt_next;
    logic [BIT_W-1:0]     tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_par_reg, tx_par_next;
    logic                 tx_line_reg, tx_line_next;
    logic                 tx_tick;

    assign tx_tick    = (tx_cnt_reg == FULL_M1);
    assign o_tx_ready = (tx_state_reg == S_IDLE) && !wb_rst;
    assign o_tx       = tx_line_reg;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_line_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_par_reg   <= tx_par_next;
            tx_line_reg  <= tx_line_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_tick ? '0 : tx_cnt_reg + 1'b1;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_line_next  = tx_line_reg;
        case (tx_state_reg)
            S_IDLE: begin
                tx_cnt_next = '0;
                if (i_tx_valid && o_tx_ready) begin
                    tx_state_next = S_START;
                    tx_shift_next = i_tx_data;
                    tx_par_next   = ^i_tx_data;
                    tx_line_next  = 1'b0;
                end
            end
            S_START: if (tx_tick) begin
                tx_state_next = S_DATA;
                tx_bit_next   = '0;
                tx_line_next  = tx_shift_reg[0];
                tx_shift_next = {1'b0, tx_shift_reg[DATA_BITS-1:1]};
            end
            S_DATA: if (tx_tick) begin
                // tx_bit_reg counts data bits already on the line.
                if (tx_bit_reg == LAST_BIT) begin
`ifdef SERVANT_UART_PARITY_EN
                    tx_state_next = S_PARITY;
                    tx_line_next  = tx_par_reg;
`else
                    tx_state_next = S_STOP;
                    tx_line_next  = 1'b1;
`endif
                end else begin
                    tx_bit_next   = tx_bit_reg + 1'b1;
                    tx_line_next  = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[DATA_BITS-1:1]};
                end
            end
            S_PARITY: if (tx_tick) begin
                tx_state_next = S_STOP;
                tx_line_next  = 1'b1;
            end
            S_STOP: if (tx_tick) tx_state_next = S_IDLE;
            default: begin
                tx_state_next = S_IDLE;
                tx_line_next  = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_servant_sim_uart.sv
// Scoreboard bench for servant_sim_uart: serial frames in, FIFO pops out, TX line sampled mid-bit.
module tb_servant_sim_uart;
    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
`ifdef SERVANT_UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          rx = 1'b1;
    logic          tx, tx_ready, rx_valid, frame_err, overflow, parity_err;
    logic          tx_valid = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic [DB-1:0] rx_data;
    logic [2:0]    rx_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int frame_start = 0;
    logic valid_d = 1'b0;
    logic [DB-1:0] exp_q[$];

    servant_sim_uart #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk(clk), .wb_rst(srst), .i_rx(rx), .o_tx(tx),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
        .o_rx_count(rx_count), .o_frame_err(frame_err), .o_overflow(overflow),
        .o_parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rx_valid && !valid_d) rise_cyc <= cyc;
        valid_d <= rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Caller is at a negedge; frame_start marks the negedge the start bit is driven.
    task automatic send_frame(input logic [DB-1:0] d, input logic par_ok, input logic stop);
        frame_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (P != 0) drive_bit(par_ok ? ^d : ~^d);
        drive_bit(stop);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        $display("rx frame sent data=0x%02h par_ok=%0b stop=%0b", d, par_ok, stop);
    endtask

    task automatic pop_one();
        int w;
        logic [DB-1:0] e;
        w = 0;
        while (!rx_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rx_valid) begin
            check("pop_timeout", rx_valid, 1);
        end else if (exp_q.size() == 0) begin
            check("sb_underflow", rx_valid, 0);
        end else begin
            e = exp_q.pop_front();
            check("rx_data", rx_data, e);
            $display("rx pop data=0x%02h expected=0x%02h", rx_data, e);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic tx_frame(input logic [DB-1:0] d);
        int j, idx;
        logic eb;
        @(negedge clk);
        check("tx_ready_idle", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
        j = 0;
        while (j < 400) begin
            @(negedge clk);
            j++;
            idx = (j - 1) / CPB;
            if (j == 1) check("tx_fall", tx, 0);
            if ((j - 1) % CPB == CPB / 2 && idx < DB + 2 + P) begin
                if (idx == 0)                      eb = 1'b0;
                else if (idx <= DB)                eb = d[idx-1];
                else if (P != 0 && idx == DB + 1)  eb = ^d;
                else                               eb = 1'b1;
                check($sformatf("tx_bit%0d", idx), tx, eb);
            end
            if (tx_ready) break;
        end
        check("tx_ready_lat", j, (DB + 2 + P) * CPB + 1);
        $display("tx frame data=0x%02h ready_after=%0d", d, j);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_count", rx_count, 0);
        check("rst_flags", {frame_err, overflow, parity_err}, 0);
        srst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);

        tx_frame(8'hA5);

        // Single frame: latency from start-bit drive to o_rx_valid rising.
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1);
        check("rx_latency", rise_cyc - frame_start, 155 + 16 * P);
        check("rx_count1", rx_count, 1);
        check("rx_flags1", {frame_err, overflow, parity_err}, 0);
        pop_one();
        check("rx_count_popped", rx_count, 0);

        // Fill past capacity without popping.
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(DB'(i));
            send_frame(DB'(i), 1'b1, 1'b1);
        end
        check("ovf_count", rx_count, DEPTH);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < DEPTH; i++) pop_one();
        check("ovf_drained", rx_valid, 0);

        // Low stop bit, then a good frame.
        send_frame(8'h5A, 1'b1, 1'b0);
        check("frame_err", frame_err, 1);
        check("frame_err_count", rx_count, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b1);
        pop_one();

        // Reset clears sticky flags.
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        check("flags_cleared", {frame_err, overflow}, 0);

        // Short low pulse is a glitch.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_count", rx_count, 0);
        check("glitch_flags", {frame_err, overflow, parity_err}, 0);

        // Reset during TX data bit 3 with one entry in the FIFO.
        send_frame(8'h11, 1'b1, 1'b1);
        check("pre_rst_count", rx_count, 1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        check("tx_bit3_low", tx, 0);
        srst = 1'b1;
        @(negedge clk);
        check("midrst_tx", tx, 1);
        check("midrst_count", rx_count, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_ready", tx_ready, 0);
        srst = 1'b0;
        @(negedge clk);
        check("midrst_ready_release", tx_ready, 1);
        $display("mid-frame reset done");

`ifdef SERVANT_UART_PARITY_EN
        tx_frame(8'h07);
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_err", parity_err, 1);
        check("par_count", rx_count, 0);
        check("par_frame_ok", frame_err, 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        pop_one();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/servant_sim_uart.md
# servant_sim_uart

Parametrised bit-serial UART endpoint for the servant simulation harness. It attaches to the SoC's serial pins: it decodes the SoC's serial output into bytes in an RX FIFO, and serialises bench-supplied bytes onto the SoC's serial input. It replaces ad-hoc console decoding with a configurable bit period, word width, FIFO depth and error reporting.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥4.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- FIFO_DEPTH, 8: RX FIFO entries; power of two, ≥2.
- wb_clk  in  1  clock.
- wb_rst  in  1  synchronous, active-high reset.
- i_rx  in  1  serial line from the SoC; idle high.
- o_tx  out  1  serial line to the SoC; idle high.
- i_tx_data  in  DATA_BITS  byte to transmit.
- i_tx_valid  in  1  TX request.
- o_tx_ready  out  1  transmitter idle; a byte is accepted when valid&ready are high on a rising edge.
- o_rx_data  out  DATA_BITS  FIFO head (first-word fall-through).
- o_rx_valid  out  1  FIFO not empty.
- i_rx_ready  in  1  pop the head when valid&ready are high.
- o_rx_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_frame_err  out  1  sticky: a stop bit was sampled low.
- o_overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
- o_parity_err  out  1  sticky: parity mismatch; tied 0 unless the parity feature is compiled in.

## Operation
- RX path:
  - i_rx passes through a 2-flop synchroniser.
  - A falling edge on the synchronised line (previous sample 1, current sample 0) in IDLE occurs at cycle E and enters START.
  - States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - START samples at E+CLKS_PER_BIT/2 (integer division). If the sample is high, the frame is treated as a glitch: return to IDLE with no error and no push.
  - Data bit k is sampled at E+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT. Parity and stop bits are sampled one bit period apart after the last data bit.
  - Stop bit low: set o_frame_err, discard the frame, go to IDLE. A new frame requires a new falling edge.
  - Stop bit high and FIFO full with no pop in that cycle: set o_overflow and discard the frame.
  - Otherwise push the frame. If a push and a pop fall in the same cycle while full, the push is accepted and the count is unchanged.
  - Popping an empty FIFO has no effect.
- TX path:
  - States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - o_tx_ready = (state==IDLE) && !wb_rst.
  - The byte is latched on handshake. The start bit (0) is driven from the next cycle, followed by the data bits LSB first, [parity], and stop (1). Each bit is held exactly CLKS_PER_BIT cycles.
  - i_tx_data may change after the handshake.
- Error flags clear only on reset.
- Reset mid-operation: both FSMs return to IDLE, o_tx=1, the FIFO is emptied, and the flags clear. Any frame in flight is abandoned.

## Timing
- Reset values:
  - o_tx=1, o_tx_ready=0 (1 in the first cycle after reset is released), o_rx_valid=0, o_rx_count=0, and all error flags 0.
  - o_rx_data is undefined whenever o_rx_valid=0.
- RX latency:
  - E occurs 2 cycles after the first rising edge at which i_rx is low (synchroniser delay).
  - The push occurs on the stop-sample edge: E+CLKS_PER_BIT/2+(DATA_BITS+1+P)·CLKS_PER_BIT, where P=1 with parity and P=0 without.
  - o_rx_valid and o_rx_count update one cycle after the push.
- TX:
  - o_tx falls 1 cycle after the handshake.
  - A frame lasts (DATA_BITS+2+P)·CLKS_PER_BIT cycles.
  - o_tx_ready reasserts in the cycle after the stop bit ends. Back-to-back frames therefore have no idle gap beyond that cycle.
- Pop: the new head and count are visible the cycle after the pop edge.

## Configuration
- SERVANT_UART_PARITY_EN defined:
  - An even-parity bit follows the data bits in both directions.
  - An RX parity mismatch sets o_parity_err and discards the frame. The stop bit is still checked, and a low stop bit also sets o_frame_err.
- SERVANT_UART_PARITY_EN undefined:
  - There is no parity bit and P=0.
  - o_parity_err is constant 0.

## Test plan
Configuration for all scenarios: CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4, no parity unless stated.
- TX 0xA5 → o_tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. o_tx_ready returns exactly 161 cycles after the handshake.
- Drive a 0x3C frame on i_rx → o_rx_valid=1, o_rx_data=0x3C, o_rx_count=1 at E+8+144+1; no error flags set.
- Drive 5 frames (0x01..0x05) with i_rx_ready=0 → o_rx_count=4, o_overflow=1. Popping then yields 0x01..0x04 in order, after which o_rx_valid=0.
- Frame with the stop bit driven low → o_frame_err=1, o_rx_count stays 0. A following good 0x55 frame is received correctly.
- i_rx low for 4 cycles, then high → no push, no flags. Assert wb_rst during TX data bit 3 → o_tx=1 on the next edge, the FIFO is emptied, and o_tx_ready=1 the first cycle after reset is released.
- With SERVANT_UART_PARITY_EN: TX 0x07 emits parity bit 1. An RX 0x07 frame with parity 0 → o_parity_err=1 and no push.
